// File: rtl/head_seq.sv
// ============================================================================
//  Module   : head_seq
//  Purpose  : Instruction sequencer. Fetches, decodes and issues memory and
//             compute operations, with a bounded wait on the compute array.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module head_seq #(
    parameter int PC_W    = 8,
    parameter int ADDR_W  = 8,
    parameter int OP_W    = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    output logic [PC_W-1:0]          imem_addr,
    input  logic [ADDR_W+OP_W-1:0]   imem_data,
    output logic                     mem_rd,
    output logic                     mem_wr,
    output logic [ADDR_W-1:0]        mem_addr,
    output logic                     acc_load,
    output logic [OP_W-1:0]          op,
    output logic                     exec_start,
    input  logic                     exec_done,
    output logic                     busy,
    output logic                     halted,
    output logic                     err,
    output logic [PC_W-1:0]          pc
);

    localparam int CNT_W = 16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_ACCESS = 3'd3,
        S_WB     = 3'd4,
        S_EXEC   = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    state_t              r_state;
    state_t              w_state_n;
    logic [PC_W-1:0]     r_pc,        w_pc_n;
    logic [PC_W-1:0]     r_imem_addr, w_imem_addr_n;
    logic [ADDR_W-1:0]   r_mem_addr,  w_mem_addr_n;
    logic [OP_W-1:0]     r_op,        w_op_n;
    logic                r_mem_rd,    w_mem_rd_n;
    logic                r_mem_wr,    w_mem_wr_n;
    logic                r_acc_load,  w_acc_load_n;
    logic                r_exec_start, w_exec_start_n;
    logic                r_busy,      w_busy_n;
    logic                r_halted,    w_halted_n;
    logic                r_err,       w_err_n;
    logic [CNT_W-1:0]    r_cnt,       w_cnt_n;

    logic [OP_W-1:0]     w_dec_op;
    logic [ADDR_W-1:0]   w_dec_addr;
    logic [PC_W-1:0]     w_pc_inc;
    logic [PC_W-1:0]     w_jmp_tgt;
    logic                w_dec_is_rd;
    logic                w_dec_is_exec;
    logic                w_op_is_exec;

    assign w_dec_op   = imem_data[OP_W-1:0];
    assign w_dec_addr = imem_data[ADDR_W+OP_W-1:OP_W];
    assign w_pc_inc   = r_pc + {{(PC_W-1){1'b0}}, 1'b1};

    assign w_dec_is_rd   = (w_dec_op == OP_W'(1)) || (w_dec_op == OP_W'(2)) ||
                           (w_dec_op == OP_W'(3));
    assign w_dec_is_exec = (w_dec_op >= OP_W'(5)) && (w_dec_op <= OP_W'(8));
    assign w_op_is_exec  = (r_op >= OP_W'(5)) && (r_op <= OP_W'(8));

    // Jump target is the low PC_W bits of the address field, zero-extended if narrower
    generate
        if (ADDR_W >= PC_W) begin : g_jmp_trunc
            assign w_jmp_tgt = r_mem_addr[PC_W-1:0];
        end else begin : g_jmp_ext
            assign w_jmp_tgt = {{(PC_W-ADDR_W){1'b0}}, r_mem_addr};
        end
    endgenerate

    always_comb begin
        w_state_n      = r_state;
        w_pc_n         = r_pc;
        w_imem_addr_n  = r_imem_addr;
        w_mem_addr_n   = r_mem_addr;
        w_op_n         = r_op;
        w_mem_rd_n     = 1'b0;
        w_mem_wr_n     = 1'b0;
        w_acc_load_n   = 1'b0;
        w_exec_start_n = 1'b0;
        w_err_n        = r_err;
        w_cnt_n        = r_cnt;

        case (r_state)
            S_IDLE, S_HALT: begin
                if (start) begin
                    w_pc_n    = '0;
                    w_err_n   = 1'b0;
                    w_state_n = S_FETCH;
                end
            end
            S_FETCH: begin
                w_state_n = S_DECODE;
            end
            S_DECODE: begin
                // Strobes are registered, so they are decided here to be high during ACCESS
                w_op_n         = w_dec_op;
                w_mem_addr_n   = w_dec_addr;
                w_mem_rd_n     = w_dec_is_rd;
                w_mem_wr_n     = (w_dec_op == OP_W'(4));
                w_exec_start_n = w_dec_is_exec;
                w_state_n      = S_ACCESS;
            end
            S_ACCESS: begin
                if (r_op == {OP_W{1'b1}}) begin
                    w_state_n = S_HALT;
                end else if (r_op == OP_W'(3)) begin
                    w_acc_load_n = 1'b1;
                    w_state_n    = S_WB;
                end else if (w_op_is_exec) begin
                    w_cnt_n   = '0;
                    w_state_n = S_EXEC;
                end else if (r_op == OP_W'(9)) begin
                    w_pc_n    = w_jmp_tgt;
                    w_state_n = S_FETCH;
                end else begin
                    w_pc_n    = w_pc_inc;
                    w_state_n = S_FETCH;
                end
            end
            S_WB: begin
                w_pc_n    = w_pc_inc;
                w_state_n = S_FETCH;
            end
            S_EXEC: begin
                // exec_done wins over a timeout landing in the same cycle
                if (exec_done) begin
                    w_pc_n    = w_pc_inc;
                    w_state_n = S_FETCH;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_err_n   = 1'b1;
                    w_state_n = S_HALT;
                end else begin
                    w_cnt_n = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                w_state_n = S_IDLE;
            end
        endcase

        if (w_state_n == S_FETCH) begin
            w_imem_addr_n = w_pc_n;
        end

        w_busy_n   = (w_state_n != S_IDLE) && (w_state_n != S_HALT);
        w_halted_n = (w_state_n == S_HALT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pc         <= '0;
            r_imem_addr  <= '0;
            r_mem_addr   <= '0;
            r_op         <= '0;
            r_mem_rd     <= 1'b0;
            r_mem_wr     <= 1'b0;
            r_acc_load   <= 1'b0;
            r_exec_start <= 1'b0;
            r_busy       <= 1'b0;
            r_halted     <= 1'b0;
            r_err        <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_state      <= w_state_n;
            r_pc         <= w_pc_n;
            r_imem_addr  <= w_imem_addr_n;
            r_mem_addr   <= w_mem_addr_n;
            r_op         <= w_op_n;
            r_mem_rd     <= w_mem_rd_n;
            r_mem_wr     <= w_mem_wr_n;
            r_acc_load   <= w_acc_load_n;
            r_exec_start <= w_exec_start_n;
            r_busy       <= w_busy_n;
            r_halted     <= w_halted_n;
            r_err        <= w_err_n;
            r_cnt        <= w_cnt_n;
        end
    end

    assign imem_addr  = r_imem_addr;
    assign mem_rd     = r_mem_rd;
    assign mem_wr     = r_mem_wr;
    assign mem_addr   = r_mem_addr;
    assign acc_load   = r_acc_load;
    assign op         = r_op;
    assign exec_start = r_exec_start;
    assign busy       = r_busy;
    assign halted     = r_halted;
    assign err        = r_err;
    assign pc         = r_pc;

endmodule

`default_nettype wire
